// File: rtl/mmio_byte_fifo.sv
// mmio_byte_fifo: CPU-mapped TX/RX byte FIFOs with valid/ready streams and sticky error flags
module mmio_byte_fifo #(
    parameter logic [31:0] BASE  = 32'h810,
    parameter int          DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    output logic [31:0] ReadData,
    output logic        Sel,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [AW:0]   tx_cnt, rx_cnt;
    logic          tx_ovf, rx_unf;
    logic          hit_d, hit_s, tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop, rd_d;
    logic [5:0]    status;
    logic          unused_bits;
    assign hit_d       = DataAdr == BASE;
    assign hit_s       = DataAdr == BASE + 32'd4;
    assign Sel         = hit_d | hit_s;
    assign tx_full     = tx_cnt == FULL;
    assign tx_empty    = tx_cnt == '0;
    assign rx_full     = rx_cnt == FULL;
    assign rx_empty    = rx_cnt == '0;
    assign tx_valid    = ~tx_empty;
    assign rx_ready    = ~rx_full;
    assign tx_data     = tx_mem[tx_rp];
    assign tx_push     = hit_d & MemWrite & ~tx_full;
    assign tx_pop      = tx_valid & tx_ready;
    assign rd_d        = hit_d & MemtoReg & ~MemWrite;
    assign rx_pop      = rd_d & ~rx_empty;
    assign rx_push     = rx_valid & rx_ready;
    assign status      = {rx_unf, tx_ovf, tx_full, tx_empty, rx_full, rx_empty};
    assign unused_bits = ^WriteData[31:8];
    // load data: RX head on a DATA load (zero when empty), flags on STATUS, zero elsewhere
    always_comb
        ReadData = (hit_d & MemtoReg & ~rx_empty) ? {24'b0, rx_mem[rx_rp]} :
                   hit_s ? {26'b0, status} : 32'b0;
    // FIFO storage; stale writes during reset are harmless since pointers reset
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= WriteData[7:0];
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end
    // TX pointers and count: CPU pushes, stream pops
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            tx_wp  <= tx_wp + AW'(tx_push);
            tx_rp  <= tx_rp + AW'(tx_pop);
            tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
        end
    end
    // RX pointers and count: stream pushes, CPU load pops
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            rx_wp  <= rx_wp + AW'(rx_push);
            rx_rp  <= rx_rp + AW'(rx_pop);
            rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        end
    end
    // sticky error flags; a coincident set beats a firmware clear
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            tx_ovf <= (hit_d & MemWrite & tx_full) | (tx_ovf & ~(hit_s & MemWrite & WriteData[4]));
            rx_unf <= (rd_d & rx_empty) | (rx_unf & ~(hit_s & MemWrite & WriteData[5]));
        end
    end
endmodule

// File: tb/tb_mmio_byte_fifo.sv
// tb_mmio_byte_fifo: directed scenario bench for mmio_byte_fifo
module tb_mmio_byte_fifo;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] DataAdr, WriteData, ReadData;
    logic        MemWrite, MemtoReg, Sel;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
    int          n_cmp = 0;
    int          n_err = 0;

    mmio_byte_fifo dut (
        .clk(clk), .reset(reset), .DataAdr(DataAdr), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ReadData(ReadData), .Sel(Sel),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    task test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        DataAdr = 32'h814; MemtoReg = 1'b1; #1;
        n_cmp++; if (ReadData !== 32'h05) begin n_err++; $display("FAIL reset_status: got %h want %h", ReadData, 32'h05); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        n_cmp++; if (Sel !== 1'b1) begin n_err++; $display("FAIL sel_status: got %b want 1", Sel); end
        DataAdr = 32'h800; #1;
        n_cmp++; if (Sel !== 1'b0) begin n_err++; $display("FAIL sel_800: got %b want 0", Sel); end
        n_cmp++; if (ReadData !== 32'h0) begin n_err++; $display("FAIL rd_800: got %h want 0", ReadData); end
        MemtoReg = 1'b0; MemWrite = 1'b1; WriteData = 32'hAB; DataAdr = 32'h818;
        @(negedge clk);
        MemWrite = 1'b0; #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL miss_store: got tx_valid %b want 0", tx_valid); end
    endtask

    task test_tx_overflow;
        logic [7:0] b [5];
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            DataAdr = 32'h810; WriteData = {24'hDEADBE, b[i]}; MemWrite = 1'b1;
        end
        @(negedge clk);
        MemWrite = 1'b0; DataAdr = 32'h814; MemtoReg = 1'b1; #1;
        n_cmp++; if (ReadData !== 32'h19) begin n_err++; $display("FAIL tx_ovf_status: got %h want %h", ReadData, 32'h19); end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== b[i]) begin n_err++; $display("FAIL tx_order[%0d]: got v=%b %h want v=1 %h", i, tx_valid, tx_data, b[i]); end
            @(negedge clk); #1;
        end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_drained: got %b want 0", tx_valid); end
        n_cmp++; if (ReadData !== 32'h15) begin n_err++; $display("FAIL tx_ovf_sticky: got %h want %h", ReadData, 32'h15); end
        tx_ready = 1'b0; MemtoReg = 1'b0; MemWrite = 1'b1; WriteData = 32'h10;
        @(negedge clk);
        MemWrite = 1'b0; MemtoReg = 1'b1; #1;
        n_cmp++; if (ReadData !== 32'h05) begin n_err++; $display("FAIL tx_ovf_clear: got %h want %h", ReadData, 32'h05); end
        MemtoReg = 1'b0;
    endtask

    task test_rx_underflow;
        @(negedge clk);
        rx_data = 8'hA0; rx_valid = 1'b1;
        @(negedge clk);
        rx_data = 8'hA1;
        @(negedge clk);
        rx_valid = 1'b0; DataAdr = 32'h810; MemtoReg = 1'b1; #1;
        n_cmp++; if (ReadData !== 32'hA0) begin n_err++; $display("FAIL rx_rd0: got %h want %h", ReadData, 32'hA0); end
        @(negedge clk); #1;
        n_cmp++; if (ReadData !== 32'hA1) begin n_err++; $display("FAIL rx_rd1: got %h want %h", ReadData, 32'hA1); end
        @(negedge clk); #1;
        n_cmp++; if (ReadData !== 32'h0) begin n_err++; $display("FAIL rx_rd_empty: got %h want 0", ReadData); end
        @(negedge clk);
        DataAdr = 32'h814; #1;
        n_cmp++; if (ReadData !== 32'h25) begin n_err++; $display("FAIL rx_unf_status: got %h want %h", ReadData, 32'h25); end
        MemtoReg = 1'b0; MemWrite = 1'b1; WriteData = 32'h20;
        @(negedge clk);
        MemWrite = 1'b0; MemtoReg = 1'b1; #1;
        n_cmp++; if (ReadData !== 32'h05) begin n_err++; $display("FAIL rx_unf_clear: got %h want %h", ReadData, 32'h05); end
        MemtoReg = 1'b0;
    endtask

    task test_rx_full;
        logic [7:0] e [3];
        e = '{8'h03, 8'h04, 8'h05};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_valid = 1'b1; rx_data = 8'(i + 1); #1;
            n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL rx_fill_ready[%0d]: got %b want 1", i, rx_ready); end
        end
        @(negedge clk);
        rx_data = 8'h05; DataAdr = 32'h810; MemtoReg = 1'b1; #1;
        n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL rx_full_ready: got %b want 0", rx_ready); end
        n_cmp++; if (ReadData !== 32'h01) begin n_err++; $display("FAIL rx_full_rd: got %h want %h", ReadData, 32'h01); end
        @(negedge clk);
        MemtoReg = 1'b0; #1;
        n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL rx_after_pop_ready: got %b want 1", rx_ready); end
        @(negedge clk);
        rx_valid = 1'b0; tx_ready = 1'b0; MemWrite = 1'b1; MemtoReg = 1'b1; WriteData = 32'h77; #1;
        n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL rx_refull_ready: got %b want 0", rx_ready); end
        @(negedge clk);
        MemWrite = 1'b0; #1;
        n_cmp++; if (ReadData !== 32'h02) begin n_err++; $display("FAIL ldst_no_pop: got %h want %h", ReadData, 32'h02); end
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin n_err++; $display("FAIL ldst_push: got v=%b %h want v=1 77", tx_valid, tx_data); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (ReadData !== {24'b0, e[i]}) begin n_err++; $display("FAIL rx_drain[%0d]: got %h want %h", i, ReadData, e[i]); end
        end
        @(negedge clk);
        MemtoReg = 1'b0; tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0; DataAdr = 32'h814; MemtoReg = 1'b1; #1;
        n_cmp++; if (ReadData !== 32'h05) begin n_err++; $display("FAIL rx_full_end_status: got %h want %h", ReadData, 32'h05); end
        MemtoReg = 1'b0;
    endtask

    task test_wrap;
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            DataAdr = 32'h810; MemWrite = 1'b1; WriteData = 32'(8'hB0 + i); #1;
            n_cmp++; if (tx_valid !== (i != 0)) begin n_err++; $display("FAIL wrap_valid[%0d]: got %b want %b", i, tx_valid, i != 0); end
            if (i != 0) begin
                n_cmp++; if (tx_data !== 8'(8'hB0 + i - 1)) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", i, tx_data, 8'(8'hB0 + i - 1)); end
            end
        end
        @(negedge clk);
        MemWrite = 1'b0; #1;
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'hB9) begin n_err++; $display("FAIL wrap_last: got v=%b %h want v=1 b9", tx_valid, tx_data); end
        @(negedge clk);
        DataAdr = 32'h814; MemtoReg = 1'b1; #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL wrap_drained: got %b want 0", tx_valid); end
        n_cmp++; if (ReadData !== 32'h05) begin n_err++; $display("FAIL wrap_status: got %h want %h", ReadData, 32'h05); end
        MemtoReg = 1'b0; tx_ready = 1'b0;
    endtask

    task test_reset_mid;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            DataAdr = 32'h810; MemWrite = 1'b1; WriteData = 32'(8'hC0 + i);
        end
        @(negedge clk);
        MemWrite = 1'b0; tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0; DataAdr = 32'h814; MemtoReg = 1'b1; #1;
        n_cmp++; if (ReadData !== 32'h11) begin n_err++; $display("FAIL pre_reset_status: got %h want %h", ReadData, 32'h11); end
        n_cmp++; if (tx_data !== 8'hC1) begin n_err++; $display("FAIL pre_reset_head: got %h want c1", tx_data); end
        reset = 1'b1; MemtoReg = 1'b0; MemWrite = 1'b1; DataAdr = 32'h810; WriteData = 32'hEE;
        @(negedge clk);
        reset = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b1; DataAdr = 32'h814; #1;
        n_cmp++; if (ReadData !== 32'h05) begin n_err++; $display("FAIL mid_reset_status: got %h want %h", ReadData, 32'h05); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_tx_valid: got %b want 0", tx_valid); end
        MemtoReg = 1'b0;
    endtask

    initial begin
        reset = 1'b1; DataAdr = '0; WriteData = '0; MemWrite = 1'b0; MemtoReg = 1'b0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        test_reset;
        test_tx_overflow;
        test_rx_underflow;
        test_rx_full;
        test_wrap;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
